sys_ctrl_bbm_seq: RTL and testbench

- Parametrised successor to the system-control passthrough that drives the analog mux-split switch banks.
- Instead of wiring bus register bits straight to the switches, it applies each new switch configuration break-before-make. Channels turning off are released first; channels turning on close only after a programmable dead time. This prevents shorting analog nets through two switches at once.
- Also carries the mgmt_select status back to the bus through a 2-flop synchroniser.
- Sits between the system-control register file and the muxsplit/vref switch pins.

---
 rtl/sys_ctrl_bbm_seq.sv | 119 +++++++++++
 tb/tb_sys_ctrl_bbm_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_bbm_seq.sv
// Break-before-make sequencer between the system-control register file and the
// analog mux-split/vref switch banks, plus a 2-flop synchroniser for mgmt_select.
module sys_ctrl_bbm_seq #(
  parameter int             NCH     = 24,
  parameter int             DEAD_W  = 8,
  parameter logic [NCH-1:0] RST_VAL = {NCH{1'b0}},
  parameter bit             AUTO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    bus_sw,
  input  logic [DEAD_W-1:0] bus_dead_cycles,
  input  logic              bus_apply,
  output logic              bus_busy,
  output logic              bus_done,
  output logic              bus_mgmt_select,
  output logic [NCH-1:0]    sw_out,
  input  logic              mgmt_select
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DEAD_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    cur_q, cur_d;
  logic [NCH-1:0]    tgt_q, tgt_d;
  logic [NCH-1:0]    sw_q, sw_d;
  logic              done_q, done_d;
  logic              sync1_q, sync2_q;

  logic [NCH-1:0]    off_bits;
  logic [NCH-1:0]    on_bits;
  logic              trigger;

  assign off_bits = cur_q & ~bus_sw;
  assign on_bits  = ~cur_q & bus_sw;
  assign trigger  = (bus_sw != cur_q) && (AUTO || bus_apply);

  // A change that only opens or only closes switches cannot short two nets,
  // so it is applied at once; a mixed change opens the off bits first.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    sw_d    = sw_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if ((off_bits == '0) || (on_bits == '0)) begin
            sw_d   = bus_sw;
            cur_d  = bus_sw;
            done_d = 1'b1;
          end else begin
            tgt_d   = bus_sw;
            sw_d    = cur_q & bus_sw;
            cnt_d   = bus_dead_cycles;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Count reaching zero still costs one cycle, so D=0 gives a full break cycle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DEAD_W'(1);
        end else begin
          sw_d    = tgt_q;
          cur_d   = tgt_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register here, including the latched target, is reset
  // asynchronously so a reset mid-sequence drops the pending make immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= RST_VAL;
      tgt_q   <= RST_VAL;
      sw_q    <= RST_VAL;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mgmt_select;
      sync2_q <= sync1_q;
    end
  end

  assign sw_out          = sw_q;
  assign bus_done        = done_q;
  assign bus_busy        = (state_q == ST_BREAK);
  assign bus_mgmt_select = sync2_q;

endmodule

// File: tb/tb_sys_ctrl_bbm_seq.sv
// Randomised and directed bench for sys_ctrl_bbm_seq; three instances cover
// AUTO=1/RST_VAL=0, AUTO=1/RST_VAL=0xF and AUTO=0/RST_VAL=0 against a timeline model.
module tb_sys_ctrl_bbm_seq;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mgmt = 1'b0;
  logic [23:0] sw_in   [NI];
  logic [7:0]  dead_in [NI];
  logic        apply_in[NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic        msel_o  [NI];
  logic [23:0] sw_o    [NI];

  int nvec  = 0;
  int nmiss = 0;
  int cyc   = 0;

  // Reference model: each mixed change schedules its make for an absolute cycle.
  logic [23:0] m_cur[NI], m_sw[NI], m_tgt[NI];
  bit          m_busy[NI], m_done[NI];
  int          m_make_at[NI];
  bit          h1, h2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sys_ctrl_bbm_seq #(
      .NCH(24), .DEAD_W(8),
      .RST_VAL((g == 1) ? 24'h00000F : 24'h000000),
      .AUTO((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .bus_sw(sw_in[g]), .bus_dead_cycles(dead_in[g]), .bus_apply(apply_in[g]),
      .bus_busy(busy_o[g]), .bus_done(done_o[g]), .bus_mgmt_select(msel_o[g]),
      .sw_out(sw_o[g]), .mgmt_select(mgmt)
    );
  end

  function automatic logic [23:0] rst_val(input int i);
    return (i == 1) ? 24'h00000F : 24'h000000;
  endfunction

  function automatic bit is_auto(input int i);
    return i != 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cur[i]  = rst_val(i);
      m_sw[i]   = rst_val(i);
      m_tgt[i]  = rst_val(i);
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  task automatic model_step(input int i);
    logic [23:0] offb, onb;
    m_done[i] = 1'b0;
    if (m_busy[i]) begin
      if (cyc == m_make_at[i]) begin
        m_sw[i]   = m_tgt[i];
        m_cur[i]  = m_tgt[i];
        m_done[i] = 1'b1;
        m_busy[i] = 1'b0;
      end
    end else if (sw_in[i] != m_cur[i] && (is_auto(i) || apply_in[i])) begin
      offb = m_cur[i] & ~sw_in[i];
      onb  = ~m_cur[i] & sw_in[i];
      if (offb == 0 || onb == 0) begin
        m_sw[i]   = sw_in[i];
        m_cur[i]  = sw_in[i];
        m_done[i] = 1'b1;
      end else begin
        m_tgt[i]     = sw_in[i];
        m_sw[i]      = m_cur[i] & sw_in[i];
        m_make_at[i] = cyc + int'(dead_in[i]) + 1;
        m_busy[i]    = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s.sw%0d", ph, i), 32'(sw_o[i]), 32'(m_sw[i]));
      check($sformatf("%s.busy%0d", ph, i), 32'(busy_o[i]), 32'(m_busy[i]));
      check($sformatf("%s.done%0d", ph, i), 32'(done_o[i]), 32'(m_done[i]));
      check($sformatf("%s.msel%0d", ph, i), 32'(msel_o[i]), 32'(h2));
    end
  endtask

  // One clock: model advances on the edge, DUT outputs compared 1ns later.
  task automatic tick(input string ph);
    logic [23:0] prev[NI];
    logic [23:0] rise, fall;
    for (int i = 0; i < NI; i++) prev[i] = sw_o[i];
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) model_step(i);
    h2 = h1;
    h1 = mgmt;
    #1;
    check_all(ph);
    for (int i = 0; i < NI; i++) begin
      rise = ~prev[i] & sw_o[i];
      fall = prev[i] & ~sw_o[i];
      check($sformatf("%s.bbm%0d", ph, i), 32'((rise != 0) && (fall != 0)), 32'(0));
    end
  endtask

  task automatic drive_all(input logic [23:0] sw, input logic [7:0] d, input logic ap);
    for (int i = 0; i < NI; i++) begin
      sw_in[i]    = sw;
      dead_in[i]  = d;
      apply_in[i] = ap;
    end
  endtask

  initial begin
    drive_all(24'h0, 8'd0, 1'b0);
    for (int i = 0; i < NI; i++) sw_in[i] = rst_val(i);
    model_reset();

    // Reset: three cycles held, then released.
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    tick("rst_rel");

    // Pure make.
    drive_all(24'h000003, 8'd0, 1'b0);
    repeat (3) tick("make");

    // Pure break to 1, then break-before-make with D=4 and D=0.
    drive_all(24'h000001, 8'd0, 1'b1);
    tick("brk");
    apply_in[2] = 1'b0;
    repeat (2) tick("brk");
    drive_all(24'h000002, 8'd4, 1'b1);
    tick("bbm4");
    apply_in[2] = 1'b0;
    repeat (7) tick("bbm4");
    drive_all(24'h000001, 8'd0, 1'b1);
    tick("bbm0");
    apply_in[2] = 1'b0;
    repeat (3) tick("bbm0");

    // Target latch and retrigger, D=3.
    drive_all(24'h000002, 8'd3, 1'b0);
    tick("latch");
    drive_all(24'h000004, 8'd3, 1'b0);
    repeat (12) tick("latch");

    // AUTO=0: no apply for 10 cycles, then apply, then apply with no change.
    drive_all(24'h000009, 8'd2, 1'b0);
    repeat (10) tick("noap");
    for (int i = 0; i < NI; i++) apply_in[i] = 1'b1;
    tick("ap");
    drive_all(24'h000009, 8'd2, 1'b0);
    repeat (6) tick("ap");
    drive_all(24'h000009, 8'd2, 1'b1);
    tick("ap_same");
    drive_all(24'h000009, 8'd2, 1'b0);
    repeat (2) tick("ap_same");

    // Maximum dead time.
    drive_all(24'h000006, 8'd255, 1'b1);
    tick("dmax");
    drive_all(24'h000006, 8'd255, 1'b0);
    repeat (258) tick("dmax");

    // Reset during a long break.
    drive_all(24'h000001, 8'd0, 1'b1);
    tick("pre6");
    apply_in[2] = 1'b0;
    repeat (3) tick("pre6");
    drive_all(24'h000002, 8'd200, 1'b1);
    tick("d200");
    apply_in[2] = 1'b0;
    repeat (50) tick("d200");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    for (int i = 0; i < NI; i++) begin
      sw_in[i]    = rst_val(i);
      apply_in[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (220) tick("post_rst");

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        apply_in[i] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) sw_in[i] = 24'($urandom);
          else sw_in[i] = sw_in[i] ^ (24'h1 << $urandom_range(0, 23));
          dead_in[i] = 8'($urandom_range(0, 6));
        end
      end
      mgmt = 1'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
